// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with redirect, stall hold buffer and IF/ID register
// One outstanding imem request; a redirect overrides stall and any coincident response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic [1:0]  next_PC_sel,
  input  logic        branch_taken,
  input  logic [31:0] target_i,
  input  logic [31:0] jalr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic        instr_valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        hold_valid;
  logic        discard;

  logic        redirect;
  logic        target_bit1;
  logic [31:0] target;
  logic        accept;
  logic        unused_lsbs;

  always_comb begin
    redirect    = (next_PC_sel == 2'b10) || (next_PC_sel == 2'b11) ||
                  ((next_PC_sel == 2'b01) && branch_taken);
    target_bit1 = (next_PC_sel == 2'b11) ? jalr_target_i[1] : target_i[1];
    target      = (next_PC_sel == 2'b11) ? {jalr_target_i[31:2], 2'b00}
                                         : {target_i[31:2], 2'b00};
    // A response is only meaningful in WAIT and when not marked stale.
    accept      = (state == WAIT) && imem_rvalid_i && !discard;
  end

  assign opcode_o    = instr_o[6:0];
  assign unused_lsbs = ^{target_i[0], jalr_target_i[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= 32'h0000_0000;
      instr_o       <= 32'h0000_0013;
      pc_o          <= 32'h0000_0000;
      instr_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      hold_instr    <= 32'h0000_0000;
      hold_pc       <= 32'h0000_0000;
      hold_valid    <= 1'b0;
      discard       <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      if (redirect) begin
        pc            <= target;
        instr_valid_o <= 1'b0;
        hold_valid    <= 1'b0;
        misalign_o    <= target_bit1;
        if (state == WAIT && !imem_rvalid_i) begin
          // Response still in flight: stay and swallow it when it lands.
          discard <= 1'b1;
        end else begin
          discard     <= 1'b0;
          state       <= REQ;
          imem_req_o  <= 1'b1;
          imem_addr_o <= target;
        end
      end else begin
        if (!stall_i) begin
          if (hold_valid) begin
            instr_o       <= hold_instr;
            pc_o          <= hold_pc;
            instr_valid_o <= 1'b1;
            hold_valid    <= 1'b0;
          end else if (accept) begin
            instr_o       <= imem_rdata_i;
            pc_o          <= imem_addr_o;
            instr_valid_o <= 1'b1;
          end else begin
            instr_valid_o <= 1'b0;
          end
        end else if (accept) begin
          hold_instr <= imem_rdata_i;
          hold_pc    <= imem_addr_o;
          hold_valid <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (!stall_i && !hold_valid) begin
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc;
            end
          end
          REQ: begin
            if (imem_gnt_i) begin
              pc         <= pc + 32'd4;
              imem_req_o <= 1'b0;
              state      <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              discard <= 1'b0;
              if (!stall_i) begin
                state       <= REQ;
                imem_req_o  <= 1'b1;
                imem_addr_o <= pc;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Memory model grants in the request cycle and answers lat cycles after the grant.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  sel;
  logic        taken;
  logic [31:0] target;
  logic [31:0] jalr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic        misalign;

  int          n_tests;
  int          n_fail;
  int          lat;
  int          cnt;
  logic        pend;
  logic [31:0] paddr;
  logic [31:0] dead_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .next_PC_sel   (sel),
    .branch_taken  (taken),
    .target_i      (target),
    .jalr_target_i (jalr_target),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr),
    .pc_o          (pc),
    .opcode_o      (opcode),
    .instr_valid_o (instr_valid),
    .misalign_o    (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory content is {A5A5, addr[15:0]} except one address that returns DEADBEEF.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!rst_n) begin
      pend     = 1'b0;
      imem_gnt = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = (paddr == dead_addr) ? 32'hDEAD_BEEF : {16'hA5A5, paddr[15:0]};
          pend        = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
      end
      imem_gnt = imem_req;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_instr"}, instr, exp_instr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; lat = 0; cnt = 0; pend = 1'b0;
    paddr = 32'h0; dead_addr = 32'hFFFF_FFF0;
    stall = 1'b0; sel = 2'b00; taken = 1'b0; target = 32'h0; jalr_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_opcode", {25'd0, opcode}, 32'h13);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    wait_valid("seq0", 32'h0, 32'hA5A5_0000);
    wait_valid("seq4", 32'h4, 32'hA5A5_0004);
    wait_valid("seq8", 32'h8, 32'hA5A5_0008);

    sel = 2'b01; taken = 1'b0; target = 32'h0000_0500;
    @(negedge clk);
    sel = 2'b00;
    wait_valid("bnt", 32'hC, 32'hA5A5_000C);

    // Taken branch lands in REQ together with a grant of the old address.
    sel = 2'b01; taken = 1'b1; target = 32'h0000_0100;
    @(negedge clk);
    sel = 2'b00; taken = 1'b0;
    check("br_valid", {31'd0, instr_valid}, 32'd0);
    check("br_req", {31'd0, imem_req}, 32'd1);
    check("br_addr", imem_addr, 32'h0000_0100);
    wait_valid("br", 32'h100, 32'hA5A5_0100);

    sel = 2'b11; jalr_target = 32'h0000_0201;
    @(negedge clk);
    sel = 2'b00;
    check("jalr1_addr", imem_addr, 32'h0000_0200);
    check("jalr1_mis", {31'd0, misalign}, 32'd0);
    wait_valid("jalr1", 32'h200, 32'hA5A5_0200);

    sel = 2'b11; jalr_target = 32'h0000_0206;
    @(negedge clk);
    sel = 2'b00;
    check("jalr2_addr", imem_addr, 32'h0000_0204);
    check("jalr2_mis", {31'd0, misalign}, 32'd1);
    @(negedge clk);
    check("jalr2_mis_end", {31'd0, misalign}, 32'd0);
    lat = 2; dead_addr = 32'h0000_0208;
    wait_valid("jalr2", 32'h204, 32'hA5A5_0204);

    // Stall from the WAIT of 0x208 until well after its response arrives.
    @(negedge clk);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_instr", instr, 32'hA5A5_0204);
    check("stall_valid", {31'd0, instr_valid}, 32'd0);
    check("stall_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    check("unstall_instr", instr, 32'hDEAD_BEEF);
    check("unstall_pc", pc, 32'h0000_0208);
    check("unstall_valid", {31'd0, instr_valid}, 32'd1);
    @(negedge clk);
    check("unstall_drop", {31'd0, instr_valid}, 32'd0);
    wait_valid("after_stall", 32'h20C, 32'hA5A5_020C);

    // JAL while the 0x210 response is still outstanding.
    @(negedge clk);
    sel = 2'b10; target = 32'h0000_0300;
    @(negedge clk);
    sel = 2'b00;
    check("disc_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid("disc", 32'h300, 32'hA5A5_0300);

    // Reset pulse while the 0x304 fetch is in WAIT.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_instr", instr, 32'h0000_0013);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("re_req", {31'd0, imem_req}, 32'd1);
    check("re_addr", imem_addr, 32'h0);
    check("re_instr", instr, 32'h0000_0013);
    wait_valid("re_seq0", 32'h0, 32'hA5A5_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
